// File: rtl/mna_pkg.sv
// rtl/mna_pkg.sv - shared flit codes, header bit positions and FSM encoding for the response unboxer
package mna_pkg;

    // Flit type field, taken from the two top bits of a flit
    localparam logic [1:0] FLIT_IDLE = 2'b00;
    localparam logic [1:0] FLIT_BODY = 2'b01;
    localparam logic [1:0] FLIT_HEAD = 2'b10;
    localparam logic [1:0] FLIT_RSVD = 2'b11;

    // Header payload layout
    localparam int HDR_WRITE_BIT = 0;
    localparam int HDR_RESP_LSB  = 1;
    localparam int HDR_RESP_MSB  = 2;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_BODY = 1'b1
    } state_t;

endpackage

// File: rtl/mna_resp_fifo.sv
// rtl/mna_resp_fifo.sv - power-of-two read-response FIFO
// Ports: clk, rst (async, active-high), push/push_data in, pop in,
//        pop_data out (head entry, zero while empty), full/empty out.
module mna_resp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Head is masked while empty so the outputs read zero out of reset
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mna_resp_unboxer.sv
// rtl/mna_resp_unboxer.sv - unpacks NoC response flits into AXI4-Lite B and R channels
// Ports: clk, rst (async, active-high); noc_valid/noc_ready/noc_data flit input;
//        bvalid/bready/bresp write-response channel; rvalid/rready/rdata/rresp read channel.
// Optional build macro MNA_UNBOXER_ERR_EN adds err_pulse and err_cnt (protocol error events).
module mna_resp_unboxer
    import mna_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FLIT_W  = DATA_W + 5,
    parameter int R_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              noc_valid,
    output logic              noc_ready,
    input  logic [FLIT_W-1:0] noc_data,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp
`ifdef MNA_UNBOXER_ERR_EN
    ,
    output logic              err_pulse,
    output logic [7:0]        err_cnt
`endif
);

    localparam int RW = DATA_W + 2;

    state_t          state;
    logic [1:0]      resp_lat;
    logic [1:0]      flit_type;
    logic [1:0]      hdr_resp;
    logic            accept;
    logic            is_head;
    logic            is_body;
    logic            r_push;
    logic            r_full;
    logic            r_empty;
    logic [RW-1:0]   r_head;
    logic            unused_bits;

    assign flit_type   = noc_data[FLIT_W-1:FLIT_W-2];
    assign hdr_resp    = noc_data[HDR_RESP_MSB:HDR_RESP_LSB];
    assign unused_bits = ^noc_data[FLIT_W-3:DATA_W];

    // Readiness depends only on registered state, never on the incoming flit
    assign noc_ready = (state == IDLE) ? !bvalid : !r_full;
    assign accept    = noc_valid && noc_ready;
    assign is_head   = accept && (flit_type == FLIT_HEAD);
    assign is_body   = accept && (flit_type == FLIT_BODY);
    assign r_push    = is_body && (state == WAIT_BODY);

    // A header is honoured in either state; one arriving in WAIT_BODY
    // abandons the read still waiting for its body.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            resp_lat <= 2'b00;
        end else if (is_head) begin
            if (noc_data[HDR_WRITE_BIT]) begin
                state <= IDLE;
            end else begin
                state    <= WAIT_BODY;
                resp_lat <= hdr_resp;
            end
        end else if (r_push) begin
            state <= IDLE;
        end
    end

    // Load wins over the handshake; in IDLE a load can only follow a
    // drained slot because noc_ready used the registered bvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid <= 1'b0;
            bresp  <= 2'b00;
        end else if (is_head && noc_data[HDR_WRITE_BIT]) begin
            bvalid <= 1'b1;
            bresp  <= hdr_resp;
        end else if (bvalid && bready) begin
            bvalid <= 1'b0;
        end
    end

    mna_resp_fifo #(
        .WIDTH (RW),
        .DEPTH (R_DEPTH)
    ) u_r_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_push),
        .push_data ({resp_lat, noc_data[DATA_W-1:0]}),
        .pop       (rvalid && rready),
        .pop_data  (r_head),
        .full      (r_full),
        .empty     (r_empty)
    );

    assign rvalid = !r_empty;
    assign rresp  = r_head[RW-1:DATA_W];
    assign rdata  = r_head[DATA_W-1:0];

`ifdef MNA_UNBOXER_ERR_EN
    logic err_event;

    // Body with no read pending, or header cutting off a pending read
    assign err_event = (is_body && (state == IDLE)) || (is_head && (state == WAIT_BODY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            err_pulse <= err_event;
            if (err_event && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mna_resp_unboxer.sv
// tb/tb_mna_resp_unboxer.sv - self-checking bench for mna_resp_unboxer
module tb_mna_resp_unboxer;

    localparam int DATA_W  = 32;
    localparam int FLIT_W  = DATA_W + 5;
    localparam int R_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              noc_valid = 1'b0;
    logic              noc_ready;
    logic [FLIT_W-1:0] noc_data = '0;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [1:0]        bresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
`ifdef MNA_UNBOXER_ERR_EN
    logic              err_pulse;
    logic [7:0]        err_cnt;
`endif

    always #5 clk = ~clk;

    mna_resp_unboxer #(
        .DATA_W  (DATA_W),
        .FLIT_W  (FLIT_W),
        .R_DEPTH (R_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .noc_valid (noc_valid),
        .noc_ready (noc_ready),
        .noc_data  (noc_data),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp)
`ifdef MNA_UNBOXER_ERR_EN
        ,
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a pending-read flag, a queue of read responses and one B slot
    logic                m_wait;
    logic [1:0]          m_lat;
    logic                m_bv;
    logic [1:0]          m_br;
    logic [DATA_W+1:0]   m_q[$];
    logic                m_ep;
    int                  m_ec;
    logic                last_acc;
    int                  pulses;

    function automatic logic m_ready();
        return m_wait ? (m_q.size() < R_DEPTH) : !m_bv;
    endfunction

    task automatic model_reset();
        m_wait = 1'b0; m_lat = 2'b00; m_bv = 1'b0; m_br = 2'b00;
        m_q.delete(); m_ep = 1'b0; m_ec = 0; last_acc = 1'b0;
    endtask

    task automatic model_step();
        logic acc;
        logic err;
        logic [1:0] typ;
        acc = noc_valid && m_ready();
        typ = noc_data[FLIT_W-1:FLIT_W-2];
        err = 1'b0;
        if (m_bv && bready) m_bv = 1'b0;
        if (m_q.size() > 0 && rready) void'(m_q.pop_front());
        if (acc) begin
            if (typ == 2'b10) begin
                if (m_wait) err = 1'b1;
                if (noc_data[0]) begin
                    m_bv = 1'b1; m_br = noc_data[2:1]; m_wait = 1'b0;
                end else begin
                    m_wait = 1'b1; m_lat = noc_data[2:1];
                end
            end else if (typ == 2'b01) begin
                if (m_wait) begin
                    m_q.push_back({m_lat, noc_data[DATA_W-1:0]});
                    m_wait = 1'b0;
                end else begin
                    err = 1'b1;
                end
            end
        end
        m_ep = err;
        if (err && m_ec < 255) m_ec++;
        last_acc = acc;
    endtask

    function automatic logic [FLIT_W-1:0] hdr(input logic w, input logic [1:0] r);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[FLIT_W-1:FLIT_W-2] = 2'b10;
        f[2:0] = {r, w};
        return f;
    endfunction

    function automatic logic [FLIT_W-1:0] body(input logic [DATA_W-1:0] d);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[FLIT_W-1:FLIT_W-2] = 2'b01;
        f[DATA_W-1:0] = d;
        return f;
    endfunction

    task automatic cycle(input logic v, input logic [FLIT_W-1:0] d, input logic br, input logic rr);
        noc_valid = v; noc_data = d; bready = br; rready = rr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
`ifdef MNA_UNBOXER_ERR_EN
        if (err_pulse) pulses++;
`endif
    endtask

    task automatic send(input logic [FLIT_W-1:0] f, input logic br, input logic rr);
        int n;
        n = 0;
        do begin
            cycle(1'b1, f, br, rr);
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
        noc_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_noc_ready", 64'(noc_ready), 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
    endtask

    // Compare process: every cycle, outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("noc_ready", 64'(noc_ready), 64'(m_ready()));
                chk("bvalid", 64'(bvalid), 64'(m_bv));
                if (m_bv) chk("bresp", 64'(bresp), 64'(m_br));
                chk("rvalid", 64'(rvalid), 64'(m_q.size() > 0));
                if (m_q.size() > 0) begin
                    chk("rdata", 64'(rdata), 64'(m_q[0][DATA_W-1:0]));
                    chk("rresp", 64'(rresp), 64'(m_q[0][DATA_W+1:DATA_W]));
                end
`ifdef MNA_UNBOXER_ERR_EN
                chk("err_pulse", 64'(err_pulse), 64'(m_ep));
                chk("err_cnt", 64'(err_cnt), 64'(m_ec));
`endif
            end
        end
    end

    initial begin
        model_reset();
        pulses = 0;
        #1;
        chk("reset_bresp", 64'(bresp), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_rresp", 64'(rresp), 64'd0);
`ifdef MNA_UNBOXER_ERR_EN
        chk("reset_err_cnt", 64'(err_cnt), 64'd0);
`endif
        do_reset();

        // Write response
        send(hdr(1'b1, 2'b10), 1'b1, 1'b1);
        chk("b_after_accept", 64'(bvalid), 64'd1);
        chk("b_resp_value", 64'(bresp), 64'd2);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("b_after_handshake", 64'(bvalid), 64'd0);

        // Single read
        send(hdr(1'b0, 2'b00), 1'b0, 1'b0);
        send(body(32'hDEADBEEF), 1'b0, 1'b0);
        chk("r_valid", 64'(rvalid), 64'd1);
        chk("r_data", 64'(rdata), 64'hDEADBEEF);
        chk("r_resp", 64'(rresp), 64'd0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("r_drained", 64'(rvalid), 64'd0);

        // Fill the R buffer, then a fifth read is held off
        for (int k = 0; k < 4; k++) begin
            send(hdr(1'b0, 2'(k)), 1'b0, 1'b0);
            send(body(32'h100 + 32'(k)), 1'b0, 1'b0);
        end
        send(hdr(1'b0, 2'b00), 1'b0, 1'b0);
        chk("full_noc_ready", 64'(noc_ready), 64'd0);
        chk("full_head", 64'(rdata), 64'h100);
        cycle(1'b0, '0, 1'b0, 1'b1);
        send(body(32'h104), 1'b0, 1'b0);
        for (int k = 1; k < 5; k++) begin
            chk("drain_data", 64'(rdata), 64'h100 + 64'(k));
            chk("drain_resp", 64'(rresp), 64'(k % 4));
            cycle(1'b0, '0, 1'b0, 1'b1);
        end
        chk("drain_empty", 64'(rvalid), 64'd0);

        // Reset mid-read with two entries buffered
        for (int k = 0; k < 2; k++) begin
            send(hdr(1'b0, 2'b01), 1'b0, 1'b0);
            send(body(32'hA0 + 32'(k)), 1'b0, 1'b0);
        end
        send(hdr(1'b0, 2'b10), 1'b0, 1'b0);
        #2;
        do_reset();
        send(body(32'h5555), 1'b0, 1'b0);
        chk("post_rst_body_dropped", 64'(rvalid), 64'd0);
        send(hdr(1'b0, 2'b01), 1'b0, 1'b0);
        send(body(32'hCAFE0001), 1'b0, 1'b0);
        chk("post_rst_data", 64'(rdata), 64'hCAFE0001);
        chk("post_rst_resp", 64'(rresp), 64'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Protocol errors
        do_reset();
        send(body(32'h1111), 1'b0, 1'b0);
        chk("idle_body_no_push", 64'(rvalid), 64'd0);
        send(hdr(1'b0, 2'b01), 1'b0, 1'b0);
        send(hdr(1'b0, 2'b11), 1'b0, 1'b0);
        send(body(32'h2222), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("err_rdata", 64'(rdata), 64'h2222);
        chk("err_rresp", 64'(rresp), 64'd3);
`ifdef MNA_UNBOXER_ERR_EN
        chk("err_cnt_two", 64'(err_cnt), 64'd2);
        chk("err_pulses_two", 64'(pulses), 64'd2);
`endif
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            logic [FLIT_W-1:0] f;
            int r;
            f = {$urandom, $urandom};
            r = int'($urandom % 8);
            if (r == 0)      f[FLIT_W-1:FLIT_W-2] = 2'b00;
            else if (r == 1) f[FLIT_W-1:FLIT_W-2] = 2'b11;
            else if (r < 5)  f[FLIT_W-1:FLIT_W-2] = 2'b10;
            else             f[FLIT_W-1:FLIT_W-2] = 2'b01;
            cycle(($urandom % 4) != 0, f, 1'($urandom % 2),
                  (i % 200 < 150) ? (($urandom % 3) != 0) : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mna_resp_unboxer.md
MNA_RESP_UNBOXER -- requirements
Module: mna_resp_unboxer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning response data width.
REQ-002 SHALL have parameter FLIT_W, default DATA_W+5, meaning NoC flit width.
REQ-003 SHALL have parameter R_DEPTH, default 4, meaning read-response FIFO entries (power of two, at least 2).
REQ-004 SHALL have port clk, in, 1, the only clock; all state on rising edge.
REQ-005 SHALL have port rst, in, 1: asynchronous, active-high reset.
REQ-006 SHALL have port noc_valid, in, 1, flit present.
REQ-007 SHALL have port noc_ready, out, 1, flit accepted when noc_valid && noc_ready.
REQ-008 SHALL have port noc_data, in, FLIT_W; [FLIT_W-1:FLIT_W-2] = type (00 idle, 10 header, 01 body, 11 reserved); header: [0] write, [2:1] resp; body: [DATA_W-1:0] data.
REQ-009 SHALL have ports bvalid out 1, bready in 1, bresp out 2: AXI4-Lite B channel.
REQ-010 SHALL have ports rvalid out 1, rready in 1, rdata out DATA_W, rresp out 2: AXI4-Lite R channel.

Function
REQ-011 SHALL implement FSM states IDLE and WAIT_BODY.
REQ-012 SHALL drive noc_ready = !b_full in IDLE and !r_full in WAIT_BODY, with no combinational path from noc_valid or noc_data.
REQ-013 SHALL, on accepted header with write=1 in IDLE, load bresp and assert bvalid next cycle; state stays IDLE.
REQ-014 SHALL, on accepted header with write=0 in IDLE, latch resp and enter WAIT_BODY.
REQ-015 SHALL, on accepted body in WAIT_BODY, push {latched resp, data} into the R FIFO and return to IDLE; rvalid rises next cycle if FIFO was empty.
REQ-016 SHALL hold bvalid/bresp stable until bvalid && bready; b_full is bvalid.
REQ-017 SHALL let a new write header and a B handshake in the same cycle be resolved as pop then load: b_full for REQ-012 is the registered value, so no same-cycle refill.
REQ-018 SHALL pop R FIFO on rvalid && rready; simultaneous push and pop when full is impossible (noc_ready low); push and pop when non-empty keeps count.
REQ-019 SHALL wrap FIFO pointers modulo R_DEPTH, with count width clog2(R_DEPTH)+1.
REQ-020 SHALL consume and ignore accepted idle (00) and reserved (11) flits in either state without state change.
REQ-021 SHALL drop an accepted body in IDLE (protocol error).
REQ-022 SHALL, on accepted header in WAIT_BODY, abandon the pending read and process the new header per REQ-013/014 (protocol error).

Reset
REQ-023 SHALL on rst force state IDLE, FIFO empty, bvalid=0, rvalid=0, bresp=0, rdata=0, rresp=0, latched resp=0 immediately, regardless of a flit or handshake in progress.
REQ-024 SHALL resume normal acceptance on the first clk edge after rst deasserts.

Configuration
REQ-025 SHALL, with MNA_UNBOXER_ERR_EN defined, add outputs err_pulse (1) and err_cnt (8): err_pulse high one cycle per REQ-021/022 event, err_cnt saturating at 255, both 0 at reset.
REQ-026 SHALL, without MNA_UNBOXER_ERR_EN, omit those ports and counter; drop/restart behaviour unchanged.

Structure
REQ-027 SHALL place flit type codes (FLIT_IDLE, FLIT_HEAD, FLIT_BODY), header bit positions and FSM state encoding in shared package mna_pkg.
REQ-028 SHALL implement the R buffer as sub-module mna_resp_fifo (parameters WIDTH, DEPTH; push/pop/full/empty).

Verification
REQ-029 SHALL check: header write=1 resp=2'b10, bready=1 -> bvalid one cycle after accept, bresp=2'b10, bvalid low after handshake.
REQ-030 SHALL check: header write=0 resp=0 then body data=32'hDEADBEEF -> rvalid, rdata=32'hDEADBEEF, rresp=0.
REQ-031 SHALL check: rready=0, 5 read packets with R_DEPTH=4 -> 4 buffered, noc_ready low in WAIT_BODY for fifth; rready=1 drains in order.
REQ-032 SHALL check: body in IDLE then header in WAIT_BODY -> no R push from first, err_cnt=2, err_pulse twice (macro on).
REQ-033 SHALL check: rst asserted in WAIT_BODY with 2 FIFO entries -> rvalid=0, bvalid=0, state IDLE immediately; next read packet returns correct data.
